// File: rtl/retire_monitor_pkg.sv
// Shared definitions for the retirement monitor: trace record layout, FSM
// encoding and counter indices.
package retire_monitor_pkg;

  localparam int REC_W         = 54;
  localparam int REC_HALT      = 53;
  localparam int REC_MEMW      = 52;
  localparam int REC_REGW      = 51;
  localparam int REC_SEL_LSB   = 48;
  localparam int REC_WDATA_LSB = 32;
  localparam int REC_ADDR_LSB  = 16;
  localparam int REC_MDATA_LSB = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam int NUM_CNT = 8;
  localparam logic [2:0] CNT_CYCLE   = 3'd0;
  localparam logic [2:0] CNT_INSTR   = 3'd1;
  localparam logic [2:0] CNT_IC_REQ  = 3'd2;
  localparam logic [2:0] CNT_IC_HIT  = 3'd3;
  localparam logic [2:0] CNT_DC_REQ  = 3'd4;
  localparam logic [2:0] CNT_DC_HIT  = 3'd5;
  localparam logic [2:0] CNT_DROP    = 3'd6;
  localparam logic [2:0] CNT_ZERO    = 3'd7;

  function automatic logic [REC_W-1:0] pack_record(
    input logic        halt,
    input logic        mem_write,
    input logic        reg_write,
    input logic [2:0]  reg_sel,
    input logic [15:0] write_data,
    input logic [15:0] mem_addr,
    input logic [15:0] mem_data
  );
    logic [REC_W-1:0] rec;
    rec                        = '0;
    rec[REC_HALT]              = halt;
    rec[REC_MEMW]              = mem_write;
    rec[REC_REGW]              = reg_write;
    rec[REC_SEL_LSB +: 3]      = reg_sel;
    rec[REC_WDATA_LSB +: 16]   = write_data;
    rec[REC_ADDR_LSB +: 16]    = mem_addr;
    rec[REC_MDATA_LSB +: 16]   = mem_data;
    return rec;
  endfunction

endpackage

// File: rtl/retire_fifo.sv
// Trace FIFO: ring buffer with an occupancy counter; a push into a full FIFO
// is dropped unless a pop frees the slot in the same cycle.
module retire_fifo #(
  parameter int WIDTH = 54,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, pop, wr;

  assign full    = (count_q == FULL_CNT);
  assign valid_o = (count_q != '0);
  assign pop     = valid_o & ready_i;
  assign wr      = push_i & (~full | pop);
  assign drop_o  = push_i & full & ~pop;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (wr && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; the empty-FIFO output mux masks stale contents to zero.
  always_ff @(posedge clk) begin
    if (wr && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/retire_monitor.sv
// Retirement monitor: RUN/HALTED FSM, saturating event counters with a
// registered readout, and a trace FIFO of retiring instructions.
module retire_monitor
  import retire_monitor_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int TRC_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regWrite,
  input  logic [2:0]       regSel,
  input  logic [15:0]      writeData,
  input  logic             memWrite,
  input  logic [15:0]      memAddr,
  input  logic [15:0]      memDataIn,
  input  logic             halt,
  input  logic             icacheReq,
  input  logic             icacheHit,
  input  logic             dcacheReq,
  input  logic             dcacheHit,
  input  logic             clear,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [REC_W-1:0] trc_data,
  output logic             halted,
  output logic             overflow
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [CNT_W-1:0] cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0] rd_data_q;
  logic             overflow_q;
  logic             live, retire, drop;

  // Only RUN cycles that are not being cleared observe the pipeline.
  assign live   = (state_q == ST_RUN) & ~clear;
  assign retire = live & (halt | regWrite | memWrite);

  retire_fifo #(.WIDTH(REC_W), .DEPTH(TRC_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (clear),
    .push_i  (retire),
    .data_i  (pack_record(halt, memWrite, regWrite, regSel, writeData, memAddr, memDataIn)),
    .ready_i (trc_ready),
    .valid_o (trc_valid),
    .data_o  (trc_data),
    .drop_o  (drop)
  );

  always_comb begin
    inc             = '0;
    inc[CNT_CYCLE]  = live;
    inc[CNT_INSTR]  = retire;
    inc[CNT_IC_REQ] = live & icacheReq;
    inc[CNT_IC_HIT] = live & icacheHit;
    inc[CNT_DC_REQ] = live & dcacheReq;
    inc[CNT_DC_HIT] = live & dcacheHit;
    inc[CNT_DROP]   = drop;
    inc[CNT_ZERO]   = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear)                        cnt_d[i] = '0;
      else if (inc[i] && ~&cnt_q[i])    cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      if (clear)                             state_q <= ST_RUN;
      else if (state_q == ST_RUN && halt)    state_q <= ST_HALTED;
      if (clear)     overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
      // Readout shows the selected counter as it stands after this edge.
      rd_data_q <= cnt_d[rd_sel];
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd_data  = rd_data_q;
  assign halted   = (state_q == ST_HALTED);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_retire_monitor.sv
// Scoreboard bench for retire_monitor: a behavioural model predicts counters,
// flags and the queue of expected trace records.
module tb_retire_monitor;

  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk, rst;
  logic          regWrite, memWrite, halt, clear, trc_ready;
  logic [2:0]    regSel, rd_sel;
  logic [15:0]   writeData, memAddr, memDataIn;
  logic          icacheReq, icacheHit, dcacheReq, dcacheHit;
  logic [CW-1:0] rd_data;
  logic          trc_valid, halted, overflow;
  logic [53:0]   trc_data;

  int checks = 0;
  int failures = 0;

  int          m_cnt [8];
  bit          m_run;
  bit          m_ovf;
  logic [53:0] sb [$];

  retire_monitor #(.CNT_W(CW), .TRC_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .regWrite(regWrite), .regSel(regSel), .writeData(writeData),
    .memWrite(memWrite), .memAddr(memAddr), .memDataIn(memDataIn), .halt(halt),
    .icacheReq(icacheReq), .icacheHit(icacheHit), .dcacheReq(dcacheReq), .dcacheHit(dcacheHit),
    .clear(clear), .rd_sel(rd_sel), .rd_data(rd_data), .trc_valid(trc_valid),
    .trc_ready(trc_ready), .trc_data(trc_data), .halted(halted), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_run = 1'b1;
    m_ovf = 1'b0;
    sb.delete();
  endtask

  task automatic bump(input int idx);
    if (m_cnt[idx] < MAXC) m_cnt[idx]++;
  endtask

  task automatic idle();
    regWrite = 0; memWrite = 0; halt = 0; clear = 0;
    regSel = 0; writeData = 0; memAddr = 0; memDataIn = 0;
    icacheReq = 0; icacheHit = 0; dcacheReq = 0; dcacheHit = 0;
  endtask

  task automatic event_in(input bit rw, input bit mw, input bit h, input logic [2:0] sel,
                          input logic [15:0] wd, input logic [15:0] ad, input logic [15:0] md);
    regWrite = rw; memWrite = mw; halt = h;
    regSel = sel; writeData = wd; memAddr = ad; memDataIn = md;
  endtask

  // One clock: predict the edge from current inputs, then compare after it.
  task automatic tick();
    logic [2:0] sel;
    bit ev;
    check("trc_valid", trc_valid, sb.size() != 0);
    if (sb.size() != 0 && trc_ready) check("trc_data", trc_data, sb.pop_front());
    sel = rd_sel;
    ev  = m_run && !clear && (halt || regWrite || memWrite);
    if (clear) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      sb.delete();
      m_ovf = 1'b0;
      m_run = 1'b1;
    end else if (m_run) begin
      bump(0);
      if (ev) bump(1);
      if (icacheReq) bump(2);
      if (icacheHit) bump(3);
      if (dcacheReq) bump(4);
      if (dcacheHit) bump(5);
      if (ev) begin
        if (sb.size() < DEPTH)
          sb.push_back({halt, memWrite, regWrite, regSel, writeData, memAddr, memDataIn});
        else begin
          bump(6);
          m_ovf = 1'b1;
        end
      end
      if (halt) m_run = 1'b0;
    end
    @(posedge clk);
    #1;
    check("rd_data", 64'(rd_data), 64'(m_cnt[sel]));
    check("halted", halted, !m_run);
    check("overflow", overflow, m_ov_f());
  endtask

  function automatic bit m_ov_f();
    return m_ovf;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"}, 64'(rd_data), 0);
    check({tag, "_trc_valid"}, trc_valid, 0);
    check({tag, "_trc_data"}, trc_data, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    rst = 1'b0; trc_ready = 1'b0; rd_sel = 3'd0;
    idle();
    model_reset();
    #12;
    check_all_zero("reset");
    #1 rst = 1'b1;

    // Single register write, consumer ready.
    trc_ready = 1'b1; rd_sel = 3'd1;
    event_in(1, 0, 0, 3'd3, 16'h1234, 16'h0000, 16'h0000);
    tick();
    check("instr_first", 64'(rd_data), 1);
    idle();
    tick();

    // Register write and store together form one record and one retirement.
    event_in(1, 1, 0, 3'd5, 16'h00AA, 16'h0040, 16'hBEEF);
    tick();
    check("instr_dual", 64'(rd_data), 2);
    idle();
    tick();

    // Six events with no consumer: four retained, two dropped.
    trc_ready = 1'b0; rd_sel = 3'd6;
    for (int i = 0; i < 6; i++) begin
      event_in(1, i[0], 0, 3'(i), 16'(16'h1000 + i), 16'(16'h0100 * i), 16'(16'hA000 + i));
      icacheReq = 1'b1; dcacheHit = i[1];
      tick();
    end
    idle();
    tick();
    check("drop_cnt", 64'(rd_data), 2);
    check("ovf_set", overflow, 1);

    // Full FIFO: simultaneous push and pop, no drop.
    trc_ready = 1'b1;
    event_in(0, 1, 0, 3'd0, 16'h0000, 16'h7777, 16'h5555);
    tick();
    trc_ready = 1'b0;
    idle();
    tick();
    check("drop_after_pp", 64'(rd_data), 2);

    // Clear wipes everything; the clear-cycle event is ignored.
    clear = 1'b1; rd_sel = 3'd0;
    event_in(1, 1, 1, 3'd1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    icacheHit = 1'b1;
    tick();
    check("clear_rd0", 64'(rd_data), 0);
    check("clear_valid", trc_valid, 0);
    idle();
    for (int s = 1; s < 8; s++) begin
      rd_sel = 3'(s);
      tick();
    end

    // Halt on the tenth cycle after reset, then five ignored events.
    rst = 1'b0; #1; rst = 1'b1;
    model_reset();
    trc_ready = 1'b0; rd_sel = 3'd0;
    idle();
    repeat (9) tick();
    event_in(1, 0, 1, 3'd7, 16'hCAFE, 16'h0000, 16'h0000);
    tick();
    for (int i = 0; i < 5; i++) begin
      event_in(1, 1, i[0], 3'd2, 16'(i), 16'(i), 16'(i));
      icacheReq = 1'b1; dcacheReq = 1'b1;
      tick();
    end
    idle();
    check("cycles_frozen", 64'(rd_data), 10);
    check("halted_set", halted, 1);
    trc_ready = 1'b1;
    tick();
    tick();

    // Saturation of the icacheHit counter.
    clear = 1'b1;
    tick();
    idle();
    rd_sel = 3'd3; icacheHit = 1'b1;
    repeat (20) tick();
    check("ichit_sat", 64'(rd_data), 64'(MAXC));

    // Reset in the middle of traffic.
    trc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      event_in(1, 0, 0, 3'd4, 16'(16'h4400 + i), 16'h0000, 16'h0000);
      tick();
    end
    rst = 1'b0;
    #2;
    check_all_zero("midrst");
    model_reset();
    idle();
    #1 rst = 1'b1;
    trc_ready = 1'b1; rd_sel = 3'd1;
    event_in(0, 1, 0, 3'd0, 16'h0000, 16'h0123, 16'h4567);
    tick();
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
